// File: rtl/seq_bcd_converter.sv
// Sequential 8-bit two's-complement to sign + 3-digit BCD converter.
// One double-dabble step per clock; valid/ready handshake on both sides.
module seq_bcd_converter (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sign,
  output logic [3:0] out_digit_1,
  output logic [3:0] out_digit_2,
  output logic [3:0] out_digit_3,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [3:0] SIGN_MINUS = 4'd15;
  localparam logic [3:0] SIGN_BLANK = 4'd14;

  state_t      state, state_nxt;
  logic        sign_q;
  logic [7:0]  mag_q;
  logic [11:0] bcd_q;
  logic [2:0]  cnt_q;

  logic        accept;
  logic        last_step;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_shift;

  function automatic logic [3:0] dabble(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == CONVERT) && (cnt_q == 3'd7);

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONVERT);
  assign out_valid = (state == DONE);

  // Correct each nibble first, then the shift pulls in the next magnitude bit.
  assign bcd_adj   = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};
  assign bcd_shift = {bcd_adj[10:0], mag_q[7]};

  // NOTE: every signal written in an always_comb gets a default at the top,
  // otherwise a missed branch infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CONVERT;
      CONVERT: if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      out_sign    <= SIGN_BLANK;
      out_digit_1 <= '0;
      out_digit_2 <= '0;
      out_digit_3 <= '0;
    end else begin
      if (accept) begin
        sign_q <= in_data[7];
        // 0x80 negates to 0x80, which read unsigned is the required 128.
        mag_q  <= in_data[7] ? (~in_data + 8'd1) : in_data;
        bcd_q  <= '0;
        cnt_q  <= '0;
      end else if (state == CONVERT) begin
        bcd_q <= bcd_shift;
        mag_q <= {mag_q[6:0], 1'b0};
        cnt_q <= cnt_q + 3'd1;
      end

      if (last_step) begin
        out_digit_3 <= bcd_shift[11:8];
        out_digit_2 <= bcd_shift[7:4];
        out_digit_1 <= bcd_shift[3:0];
        out_sign    <= sign_q ? SIGN_MINUS : SIGN_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Directed and exhaustive bench for seq_bcd_converter; outputs sampled 1 time
// unit after each rising edge, results compared as {sign, d3, d2, d1}.
module tb_seq_bcd_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sign;
  logic [3:0] out_digit_1;
  logic [3:0] out_digit_2;
  logic [3:0] out_digit_3;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  seq_bcd_converter dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_digit_1 (out_digit_1),
    .out_digit_2 (out_digit_2),
    .out_digit_3 (out_digit_3),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] result_code();
    return {out_sign, out_digit_3, out_digit_2, out_digit_1};
  endfunction

  // Independent decimal model: sign code then hundreds/tens/units.
  function automatic logic [15:0] ref_code(input logic [7:0] v);
    int s;
    int m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    return {(s < 0) ? 4'd15 : 4'd14, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept v, check the 8-cycle latency and result, hold out_ready low for
  // hold cycles, then release and check the return to IDLE.
  task automatic convert_and_check(input logic [7:0] v, input logic [15:0] exp_code,
                                   input int hold, input bit noise, input bit rand_bp);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = v;
    out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_in_convert", 32'(in_ready), 32'd0);
    for (int i = 0; i < 7; i++) begin
      in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = noise ? 8'($urandom) : v;
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      check("out_valid_early", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    step();
    check("out_valid_at_latency", 32'(out_valid), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    check("result", 32'(result_code()), 32'(exp_code));
    for (int i = 0; i < hold; i++) begin
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = 8'($urandom);
      step();
      check("out_valid_held", 32'(out_valid), 32'd1);
      check("in_ready_held_low", 32'(in_ready), 32'd0);
      check("result_held", 32'(result_code()), 32'(exp_code));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_release", 32'(out_valid), 32'd0);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    check("result_kept_in_idle", 32'(result_code()), 32'(exp_code));
  endtask

  initial begin
    int  rise_a;
    int  rise_b;
    bit  prev_valid;
    bit  saw_valid;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'(result_code()), 32'h0000_E000);

    convert_and_check(8'h00, 16'hE000, 0, 1'b0, 1'b0);
    convert_and_check(8'h7F, 16'hE127, 0, 1'b0, 1'b0);
    convert_and_check(8'h80, 16'hF128, 0, 1'b0, 1'b0);
    convert_and_check(8'hFF, 16'hF001, 0, 1'b0, 1'b0);
    // -10 with 5 cycles of backpressure and noisy in_valid/in_data.
    convert_and_check(8'hF6, 16'hF010, 5, 1'b1, 1'b0);

    // Reset wins over in_valid in IDLE.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h12;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("reset_prio_busy", 32'(busy), 32'd0);
    check("reset_prio_in_ready", 32'(in_ready), 32'd1);
    check("reset_prio_result", 32'(result_code()), 32'h0000_E000);

    // Load a nonzero result so the abort test sees the outputs cleared.
    convert_and_check(8'd85, 16'hE085, 0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("abort_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result_code()), 32'h0000_E000);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_valid_pulse", 32'(saw_valid), 32'd0);

    // Back-to-back: in_valid held high, out_ready tied high -> 10-cycle period.
    in_valid   = 1'b1;
    in_data    = 8'd42;
    out_ready  = 1'b1;
    rise_a     = -1;
    rise_b     = -1;
    prev_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid && !prev_valid) begin
        if (rise_a < 0) rise_a = i;
        else if (rise_b < 0) rise_b = i;
      end
      prev_valid = out_valid;
    end
    in_valid  = 1'b0;
    check("b2b_first_latency", 32'(rise_a), 32'd8);
    check("b2b_period", 32'(rise_b - rise_a), 32'd10);
    check("b2b_result", 32'(result_code()), 32'h0000_E042);
    for (int i = 0; i < 12 && !in_ready; i++) step();
    out_ready = 1'b0;
    check("b2b_back_to_idle", 32'(in_ready), 32'd1);

    // Exhaustive sweep against the decimal model with random backpressure.
    for (int v = 0; v < 256; v++) begin
      convert_and_check(8'(v), ref_code(8'(v)), $urandom_range(0, 3), 1'b1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_bcd_converter.md
SEQ_BCD_CONVERTER -- requirements
Module: seq_bcd_converter

Interface
REQ-001 Port list, one clock domain; reset synchronous, active-high (the polarity and synchronicity are fixed):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  in_data valid
- in_data  input  8  two's-complement value, e.g. the I/O-mapped outmapped byte
- in_ready  output  1  block can accept in_data
- out_valid  output  1  result registers hold a fresh result
- out_ready  input  1  consumer accepts the result
- out_sign  output  4  sign code: 15 = minus, 14 = blank
- out_digit_1  output  4  BCD units
- out_digit_2  output  4  BCD tens
- out_digit_3  output  4  BCD hundreds
- busy  output  1  conversion in progress
REQ-002 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 The FSM SHALL have three states: IDLE, CONVERT, DONE.
REQ-004 In IDLE, in_ready SHALL be 1; in CONVERT and DONE, in_ready SHALL be 0.
REQ-005 Acceptance SHALL occur on a rising edge where state is IDLE and in_valid is 1.
REQ-006 On acceptance, the block SHALL register sign = in_data[7].
REQ-007 On acceptance, the block SHALL register the 8-bit unsigned magnitude: in_data if non-negative, else the two's-complement negation (0x80 gives magnitude 128).
REQ-008 On acceptance, the block SHALL clear the 12-bit BCD scratch, clear the 3-bit step counter, and enter CONVERT.
REQ-009 In CONVERT, each edge SHALL perform one double-dabble step:
- add 3 to every BCD nibble that is >= 5;
- then shift {BCD, magnitude} left by 1.
REQ-010 After the 8th CONVERT step (counter == 7), the block SHALL load the result into out_digit_3..1 and out_sign, and enter DONE.
REQ-011 Latency SHALL be exactly 8 cycles: out_valid goes high after the 8th edge following the accepting edge.
REQ-012 out_sign SHALL be 15 only when the registered sign is 1; zero and positive values give 14.
REQ-013 out_valid SHALL be 1 in DONE only.
REQ-014 busy SHALL be 1 in CONVERT only.
REQ-015 In DONE with out_ready == 1, the FSM SHALL return to IDLE on that edge; out_valid falls and in_ready rises in the following cycle.
REQ-016 In DONE with out_ready == 0, the FSM SHALL remain in DONE with all outputs held stable, for an unbounded number of cycles.
REQ-017 in_valid SHALL be ignored in CONVERT and DONE.
REQ-018 Changes on in_data after acceptance SHALL NOT affect the result.
REQ-019 out_digit_* and out_sign SHALL change only on the REQ-010 load or on reset; between results they hold the last completed value.
REQ-020 Back-to-back operation SHALL be supported: a new value offered while in_valid stays high is accepted on the first IDLE edge, giving a 10-cycle period with out_ready tied to 1.
REQ-021 All BCD digits SHALL be in range 0-9 for every input -128..127.
REQ-022 No arithmetic overflow SHALL be possible: the maximum magnitude is 128.

Reset
REQ-023 When reset is 1 on an edge, the block SHALL force:
- state = IDLE;
- in_ready = 1, out_valid = 0, busy = 0;
- out_sign = 14;
- out_digit_1 = out_digit_2 = out_digit_3 = 0;
- step counter and scratch registers = 0.
REQ-024 Reset SHALL take priority over every other event, including in_valid and out_ready on the same edge.
REQ-025 Reset asserted during CONVERT or DONE SHALL abort the conversion, and no result SHALL be produced for the aborted input.

Verification
REQ-026 The bench SHALL cover these directed scenarios (stimulus -> required response):
- in_data = 0x00 accepted -> 8 cycles later: out_valid = 1, sign 14, digits 0/0/0.
- in_data = 0x7F (127) -> sign 14, digits 1/2/7.
- in_data = 0x80 (-128) -> sign 15, digits 1/2/8.
- in_data = 0xFF (-1) -> sign 15, digits 0/0/1.
- in_data = 0xF6 (-10) with out_ready low for 5 cycles -> out_valid and outputs stable for 5 cycles; IDLE one cycle after out_ready rises.
- Accept 0x55 (85), assert reset at the 4th CONVERT cycle -> next cycle IDLE, sign 14, digits 0/0/0, and no out_valid pulse.
REQ-027 The bench SHALL compare all 256 in_data values against a reference decimal model, with random out_ready backpressure.
